// File: rtl/rotor_offset_wrapper.sv
// rotor_offset_wrapper: two-stage rotor offset with mod-26 wrap, rotor position counter and notch output
module rotor_offset_wrapper (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_letter,
  input  logic       dir,
  input  logic       load,
  input  logic [4:0] load_pos,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_letter,
  output logic       out_error,
  output logic [4:0] pos,
  output logic       notch
);
  logic       en, acc, in_err, s1_valid, s1_dir, s1_err;
  logic [7:0] s1_ntcv, s1_letter, wrapped;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign acc      = in_valid && en;
  assign in_err   = (in_letter < 8'h41) || (in_letter > 8'h5A);
  always_comb
    wrapped = s1_dir ? ((s1_ntcv < 8'h41) ? s1_ntcv + 8'd26 : s1_ntcv)
                     : ((s1_ntcv > 8'h5A) ? s1_ntcv - 8'd26 : s1_ntcv);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_dir     <= 1'b0;
      s1_err     <= 1'b0;
      s1_ntcv    <= 8'h00;
      s1_letter  <= 8'h00;
      out_valid  <= 1'b0;
      out_letter <= 8'h00;
      out_error  <= 1'b0;
      pos        <= 5'd0;
      notch      <= 1'b0;
    end else begin
      if (en) begin
        s1_valid <= in_valid;
        if (acc) begin
          s1_dir    <= dir;
          s1_err    <= in_err;
          s1_letter <= in_letter;
          s1_ntcv   <= dir ? in_letter - {3'b000, pos} : in_letter + {3'b000, pos};
        end
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_letter <= s1_err ? s1_letter : wrapped;
          out_error  <= s1_err;
        end
      end
      // load overrides stepping and never produces a notch
      if (load)
        pos <= (load_pos > 5'd25) ? load_pos - 5'd26 : load_pos;
      else if (acc && !in_err)
        pos <= (pos == 5'd25) ? 5'd0 : pos + 5'd1;
      notch <= acc && !in_err && !load && (pos == 5'd25);
    end
endmodule
